// File: rtl/frv_mdu_pkg.sv
// rtl/frv_mdu_pkg.sv - shared constants, state encoding and helpers for the iterative MDU
package frv_mdu_pkg;

    localparam int XLEN      = 32;
    localparam int XL        = XLEN - 1;
    localparam int MDU_ITERS = 32;
    localparam int MDU_CNT_W = 5;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    localparam logic [MDU_CNT_W-1:0] MDU_LAST = MDU_CNT_W'(MDU_ITERS - 1);

    function automatic logic [XL:0] mdu_abs(input logic [XL:0] v, input logic sgn);
        return sgn ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/frv_mdu_addsub.sv
// rtl/frv_mdu_addsub.sv - 33-bit adder/subtractor shared by multiply add and divide trial subtract
module frv_mdu_addsub
    import frv_mdu_pkg::*;
(
    input  logic [XLEN:0] a_i,
    input  logic [XLEN:0] b_i,
    input  logic          sub_i,
    output logic [XLEN:0] sum_o,
    output logic          carry_o
);

    logic [XLEN:0]   b_x;
    logic [XLEN+1:0] full;

    // When subtracting, carry_o=1 means no borrow (a >= b).
    assign b_x     = sub_i ? ~b_i : b_i;
    assign full    = {1'b0, a_i} + {1'b0, b_x} + (XLEN+2)'(sub_i);
    assign sum_o   = full[XLEN:0];
    assign carry_o = full[XLEN+1];

endmodule

// File: rtl/frv_mdu.sv
// rtl/frv_mdu.sv - RV32M iterative multiply/divide unit with valid/ready/ack handshake
module frv_mdu
    import frv_mdu_pkg::*;
(
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          flush,
    input  logic          valid,
    input  logic          ack,
    input  logic          op_mul,
    input  logic          op_mulh,
    input  logic          op_mulhsu,
    input  logic          op_mulhu,
    input  logic          op_div,
    input  logic          op_divu,
    input  logic          op_rem,
    input  logic          op_remu,
    input  logic [XL:0]   rs1,
    input  logic [XL:0]   rs2,
    output logic          busy,
    output logic          ready,
    output logic [XL:0]   result
);

    mdu_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]   count_q, count_d;
    logic [2*XLEN-1:0]      acc_q, acc_d;
    logic [XL:0]            b_q, b_d;
    logic                   neg_q, neg_d;
    logic                   sel_hi_q, sel_hi_d;
    logic                   is_div_q, is_div_d;
    logic                   busy_q, ready_q;

    logic                   any_op, div_op, div_zero, div_ovf;
    logic                   sgn_a, sgn_b;
    logic [XL:0]            abs_a, abs_b;

    logic [XLEN:0]          as_a, as_b, as_sum;
    logic                   as_sub, as_carry;

    assign any_op   = op_mul | op_mulh | op_mulhsu | op_mulhu |
                      op_div | op_divu | op_rem | op_remu;
    assign div_op   = op_div | op_divu | op_rem | op_remu;
    assign sgn_a    = rs1[XL] & (op_mulh | op_mulhsu | op_div | op_rem);
    assign sgn_b    = rs2[XL] & (op_mulh | op_div | op_rem);
    assign abs_a    = mdu_abs(rs1, sgn_a);
    assign abs_b    = mdu_abs(rs2, sgn_b);
    assign div_zero = div_op && (rs2 == '0);
    assign div_ovf  = (op_div | op_rem) && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

    // MUL adds the multiplicand into hi; DIV subtracts the divisor from {rem, quo msb}.
    assign as_sub = (state_q == MDU_DIV);
    assign as_a   = as_sub ? acc_q[2*XLEN-1:XL] : {1'b0, acc_q[2*XLEN-1:XLEN]};
    assign as_b   = {1'b0, b_q};

    frv_mdu_addsub u_addsub (
        .a_i     (as_a),
        .b_i     (as_b),
        .sub_i   (as_sub),
        .sum_o   (as_sum),
        .carry_o (as_carry)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        b_d      = b_q;
        neg_d    = neg_q;
        sel_hi_d = sel_hi_q;
        is_div_d = is_div_q;

        case (state_q)
            MDU_IDLE: begin
                if (valid && any_op) begin
                    count_d  = '0;
                    sel_hi_d = op_mulh | op_mulhsu | op_mulhu | op_rem | op_remu;
                    is_div_d = div_op;
                    if (div_zero) begin
                        // quo=all ones, rem=dividend; no sign fix-up
                        acc_d   = {rs1, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        state_d = MDU_DONE;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, 32'h8000_0000};
                        neg_d   = 1'b0;
                        state_d = MDU_DONE;
                    end else if (div_op) begin
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        b_d     = abs_b;
                        neg_d   = op_div ? (rs1[XL] ^ rs2[XL]) : (op_rem & rs1[XL]);
                        state_d = MDU_DIV;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, abs_b};
                        b_d     = abs_a;
                        neg_d   = op_mulh ? (rs1[XL] ^ rs2[XL]) : (op_mulhsu & rs1[XL]);
                        state_d = MDU_MUL;
                    end
                end
            end
            MDU_MUL: begin
                if (acc_q[0]) begin
                    acc_d = {as_sum, acc_q[XL:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                end
                count_d = count_q + MDU_CNT_W'(1);
                if (count_q == MDU_LAST) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DIV: begin
                if (as_carry) begin
                    acc_d = {as_sum[XL:0], acc_q[XL-1:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end
                count_d = count_q + MDU_CNT_W'(1);
                if (count_q == MDU_LAST) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                if (ack) begin
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase

        if (flush) begin
            state_d = MDU_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= MDU_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            sel_hi_q <= sel_hi_d;
            is_div_q <= is_div_d;
            busy_q   <= (state_d != MDU_IDLE);
            ready_q  <= (state_d == MDU_DONE);
        end
    end

    logic [2*XLEN-1:0] neg_prod;
    logic [XL:0]       field, field_neg;

    // Products negate as 64 bits; quotient and remainder negate independently.
    assign neg_prod  = ~acc_q + 64'd1;
    assign field     = sel_hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XL:0];
    assign field_neg = is_div_q ? (~field + XLEN'(1))
                                : (sel_hi_q ? neg_prod[2*XLEN-1:XLEN] : neg_prod[XL:0]);

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign result = ready_q ? (neg_q ? field_neg : field) : '0;

endmodule

// File: tb/tb_frv_mdu.sv
// tb/tb_frv_mdu.sv - table-driven self-checking bench for frv_mdu
module tb_frv_mdu;

    logic        g_clk = 1'b0;
    logic        g_reset, flush, valid, ack;
    logic [7:0]  ops;
    logic [31:0] rs1, rs2;
    logic        busy, ready;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] OP_MUL = 8'h01, OP_MULH = 8'h02, OP_MULHSU = 8'h04, OP_MULHU = 8'h08;
    localparam logic [7:0] OP_DIV = 8'h10, OP_DIVU = 8'h20, OP_REM = 8'h40, OP_REMU = 8'h80;

    always #5 g_clk = ~g_clk;

    frv_mdu dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .flush     (flush),
        .valid     (valid),
        .ack       (ack),
        .op_mul    (ops[0]),
        .op_mulh   (ops[1]),
        .op_mulhsu (ops[2]),
        .op_mulhu  (ops[3]),
        .op_div    (ops[4]),
        .op_divu   (ops[5]),
        .op_rem    (ops[6]),
        .op_remu   (ops[7]),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy      (busy),
        .ready     (ready),
        .result    (result)
    );

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives a request, returns result and ready latency in cycles after acceptance; acks at once.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] res, output int cyc);
        int n = 0;
        valid = 1'b1; ops = op; rs1 = a; rs2 = b;
        do begin
            @(posedge g_clk); #1;
            n++;
        end while (!ready && n < 80);
        cyc = n;
        res = result;
        if (!ready) begin
            cyc = -1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge g_clk); #1;
            check("hold_ready", 32'(ready), 32'd1);
            check("hold_result", result, res);
        end
        ack = 1'b1;
        @(posedge g_clk); #1;
        ack = 1'b0; valid = 1'b0; ops = '0;
        check("busy_after_ack", 32'(busy), 32'd0);
        @(posedge g_clk); #1;
    endtask

    logic [31:0] r;
    int          c;
    logic        saw_ready;

    initial begin
        g_reset = 1'b1; flush = 1'b0; valid = 1'b0; ack = 1'b0;
        ops = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge g_clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_result", result, 32'd0);
        g_reset = 1'b0;
        @(posedge g_clk); #1;

        vecs.push_back('{"mul_7_m3",      OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        vecs.push_back('{"mulhu_7_m3",    OP_MULHU,  32'd7,          32'hFFFFFFFD, 32'h00000006, 33});
        vecs.push_back('{"mulh_min_min",  OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33});
        vecs.push_back('{"mulhu_ff_ff",   OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{"mulhsu_ff_ff",  OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        vecs.push_back('{"mulh_m3_7",     OP_MULH,   32'hFFFFFFFD,   32'd7,        32'hFFFFFFFF, 33});
        vecs.push_back('{"mul_big_9",     OP_MUL,    32'h12345678,   32'd9,        32'hA3D70A38, 33});
        vecs.push_back('{"div_m7_2",      OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_m7_2",      OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{"divu_100_7",    OP_DIVU,   32'd100,        32'd7,        32'd14,       33});
        vecs.push_back('{"remu_100_7",    OP_REMU,   32'd100,        32'd7,        32'd2,        33});
        vecs.push_back('{"div_5_0",       OP_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"rem_5_0",       OP_REM,    32'd5,          32'd0,        32'd5,        1});
        vecs.push_back('{"divu_0_0",      OP_DIVU,   32'd0,          32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"remu_5_0",      OP_REMU,   32'd5,          32'd0,        32'd5,        1});
        vecs.push_back('{"div_ovf",       OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"rem_ovf",       OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1});

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, c);
            check({vecs[i].name, "_res"}, r, vecs[i].exp);
            check({vecs[i].name, "_cyc"}, 32'(c), 32'(vecs[i].cyc));
        end

        // Flush a DIV in cycle 10, then issue MUL 3x4 in cycle 11.
        saw_ready = 1'b0;
        valid = 1'b1; ops = OP_DIV; rs1 = 32'd100; rs2 = 32'd7;
        for (int n = 1; n <= 10; n++) begin
            @(posedge g_clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        valid = 1'b0; ops = '0;
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(ready), 32'd0);
        check("flush_no_ready_pulse", 32'(saw_ready), 32'd0);
        run_op(OP_MUL, 32'd3, 32'd4, 0, r, c);
        check("mul_after_flush_res", r, 32'd12);
        check("mul_after_flush_cyc", 32'(c), 32'd33);

        // ack withheld for 5 cycles in DONE
        run_op(OP_DIVU, 32'd100, 32'd7, 5, r, c);
        check("hold_divu_res", r, 32'd14);

        // reset asserted mid-MUL discards the operation
        valid = 1'b1; ops = OP_MUL; rs1 = 32'd5; rs2 = 32'd6;
        repeat (6) @(posedge g_clk);
        #1;
        valid = 1'b0; ops = '0;
        check("mid_mul_busy", 32'(busy), 32'd1);
        g_reset = 1'b1;
        @(posedge g_clk); #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd0);
        check("rst_mid_result", result, 32'd0);
        g_reset = 1'b0;
        @(posedge g_clk); #1;
        run_op(OP_MUL, 32'd5, 32'd6, 0, r, c);
        check("mul_after_reset", r, 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
